// File: rtl/sig_period_monitor_if.sv
// Bundle of the oscillator pulse input and the period/fault reporting outputs.
// master: the monitor itself. slave: the consumer/driver side.
interface sig_period_monitor_if #(
  parameter int PW = 16
);
  logic          sig_in;
  logic [PW-1:0] period_out;
  logic          period_valid;
  logic          fault;
  logic [1:0]    fault_code;
  logic [7:0]    pulse_cnt;

  modport master (
    input  sig_in,
    output period_out, period_valid, fault, fault_code, pulse_cnt
  );

  modport slave (
    output sig_in,
    input  period_out, period_valid, fault, fault_code, pulse_cnt
  );
endinterface

// File: rtl/sig_period_monitor.sv
// Rising-edge period monitor for the oscillator's sig output.
// Measures cycles between rises and flags short / long / timeout against
// EXP_PERIOD +/- TOL.
// Optional macro PERIOD_MON_STICKY_FAULT_EN: faults latch until rst.
// Without it, fault is a one-cycle pulse and monitoring resumes at once.
module sig_period_monitor #(
  parameter int EXP_PERIOD = 35002,
  parameter int TOL        = 0,
  parameter int PW         = 16
) (
  input logic clk,
  input logic rst,
  sig_period_monitor_if.master mon
);

  typedef enum logic [1:0] {ARMED, MEAS, FAULT} state_e;

  localparam int            SHORT_MIN_I = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam logic [PW-1:0] SHORT_MIN   = PW'(SHORT_MIN_I);
  localparam logic [PW-1:0] HI_LIM      = PW'(EXP_PERIOD + TOL);
  localparam logic [PW-1:0] TMO_LIM     = PW'(EXP_PERIOD + TOL + 1);

  localparam logic [1:0] CODE_SHORT = 2'b01;
  localparam logic [1:0] CODE_LONG  = 2'b10;
  localparam logic [1:0] CODE_TMO   = 2'b11;

  state_e        state_q, state_d;
  logic          sig_dly_q, sig_dly_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] period_q, period_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;
  logic [7:0]    pulse_q, pulse_d;

  logic          rise;
  logic          evt;
  logic [1:0]    evt_code;

  // Edge detect and fault-event decode for the current cycle.
  // A long period implies the counter has hit the timeout limit, so the
  // timeout test is ordered first and wins.
  always_comb begin
    rise     = mon.sig_in & ~sig_dly_q;
    evt      = 1'b0;
    evt_code = 2'b00;
    case (state_q)
      ARMED: begin
        if (!rise && cnt_q >= TMO_LIM) begin
          evt      = 1'b1;
          evt_code = CODE_TMO;
        end
      end
      MEAS: begin
        if (cnt_q >= TMO_LIM) begin
          evt      = 1'b1;
          evt_code = CODE_TMO;
        end else if (rise && cnt_q > HI_LIM) begin
          evt      = 1'b1;
          evt_code = CODE_LONG;
        end else if (rise && cnt_q < SHORT_MIN) begin
          evt      = 1'b1;
          evt_code = CODE_SHORT;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED: begin
`ifdef PERIOD_MON_STICKY_FAULT_EN
        if (evt)       state_d = FAULT;
        else if (rise) state_d = MEAS;
`else
        if (!evt && rise) state_d = MEAS;
`endif
      end
      MEAS: begin
`ifdef PERIOD_MON_STICKY_FAULT_EN
        if (evt) state_d = FAULT;
`else
        if (evt && evt_code == CODE_TMO) state_d = ARMED;
`endif
      end
`ifdef PERIOD_MON_STICKY_FAULT_EN
      FAULT:   state_d = FAULT;
`else
      FAULT:   state_d = ARMED;
`endif
      default: state_d = ARMED;
    endcase
  end

  // Datapath and output register inputs.
  always_comb begin
    sig_dly_d = mon.sig_in;
    pulse_d   = (rise && pulse_q != '1) ? pulse_q + 8'd1 : pulse_q;

    if (rise)              cnt_d = PW'(1);
    else if (cnt_q == '1)  cnt_d = cnt_q;
    else                   cnt_d = cnt_q + PW'(1);
`ifndef PERIOD_MON_STICKY_FAULT_EN
    // A timeout discards any coincident rise: the monitor re-arms from zero.
    if (evt && evt_code == CODE_TMO) cnt_d = '0;
`endif

    valid_d  = (state_q == MEAS) && rise;
    period_d = valid_d ? cnt_q : period_q;
    code_d   = evt ? evt_code : code_q;
`ifdef PERIOD_MON_STICKY_FAULT_EN
    fault_d  = fault_q | evt;
`else
    fault_d  = evt;
`endif
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARMED;
      sig_dly_q <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= 2'b00;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      sig_dly_q <= sig_dly_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      pulse_q   <= pulse_d;
    end
  end

  assign mon.period_out   = period_q;
  assign mon.period_valid = valid_q;
  assign mon.fault        = fault_q;
  assign mon.fault_code   = code_q;
  assign mon.pulse_cnt    = pulse_q;

endmodule

// File: tb/tb_sig_period_monitor.sv
// Bench for sig_period_monitor (EXP_PERIOD=10, TOL=1, PW=8).
// Directed vector table plus hand sequences plus random pulse trains, all
// checked every cycle against a timestamp-based reference model.
module tb_sig_period_monitor;

  localparam int EXP = 10;
  localparam int TOL = 1;
  localparam int PW  = 8;
  localparam int LIM = EXP + TOL + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sig_period_monitor_if #(.PW(PW)) bus ();

  sig_period_monitor #(.EXP_PERIOD(EXP), .TOL(TOL), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: times measured in edge indices.
  int   m_n = 0;      // index of the latest edge
  int   m_t0 = 0;     // edge index at which the elapsed count was zero
  bit   m_meas = 0;   // a first rise has been seen
  bit   m_stuck = 0;
  bit   m_prev = 0;
  int   m_period = 0;
  bit   m_valid = 0;
  bit   m_fault = 0;
  int   m_code = 0;
  int   m_pulse = 0;
  bit   prev_valid = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic raise(input int code);
    m_fault = 1;
    m_code  = code;
`ifdef PERIOD_MON_STICKY_FAULT_EN
    m_stuck = 1;
`else
    if (code == 3) begin
      m_meas = 0;
      m_t0   = m_n;
    end
`endif
  endtask

  task automatic model_edge(input logic r, input logic s);
    bit rise;
    int el;
    m_n++;
    if (r) begin
      m_prev = 0; m_t0 = m_n; m_meas = 0; m_stuck = 0;
      m_period = 0; m_valid = 0; m_fault = 0; m_code = 0; m_pulse = 0;
      return;
    end
    rise   = s && !m_prev;
    m_prev = s;
    el = m_n - 1 - m_t0;
    if (el > 255) el = 255;
    if (rise && m_pulse < 255) m_pulse++;
    m_valid = 0;
`ifdef PERIOD_MON_STICKY_FAULT_EN
    if (m_stuck) return;
`else
    m_fault = 0;
`endif
    if (!m_meas) begin
      if (rise) begin
        m_meas = 1;
        m_t0   = m_n - 1;
      end else if (el >= LIM) begin
        raise(3);
      end
    end else begin
      if (rise) begin
        m_valid  = 1;
        m_period = el;
      end
      if (el >= LIM) raise(3);
      else if (rise) begin
        m_t0 = m_n - 1;
        if (el < EXP - TOL) raise(1);
      end
    end
  endtask

  task automatic check_model();
    chk("period_out",   int'(bus.period_out),   m_period);
    chk("period_valid", int'(bus.period_valid), int'(m_valid));
    chk("fault",        int'(bus.fault),        int'(m_fault));
    chk("fault_code",   int'(bus.fault_code),   m_code);
    chk("pulse_cnt",    int'(bus.pulse_cnt),    m_pulse);
    chk("valid_back_to_back", int'(prev_valid && bus.period_valid), 0);
    prev_valid = bus.period_valid;
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic s);
    rst        = r;
    bus.sig_in = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
    check_model();
  endtask

  // Next rise exactly gap edges after the previous one (which lasted prev_w).
  task automatic run_to_rise(input int gap, input int prev_w);
    for (int i = 1; i < gap; i++) step(1'b0, i < prev_w);
    step(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  typedef struct {
    int gap; int w;
    int valid; int period; int fault; int code; int pulse;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int prev_w;
    int gap, w, ph;
    bus.sig_in = 1'b0;

    vecs[0] = '{10, 1, 1, 10, 0, 0, 2};
    vecs[1] = '{10, 2, 1, 10, 0, 0, 3};
    vecs[2] = '{10, 2, 1, 10, 0, 0, 4};
    vecs[3] = '{ 9, 1, 1,  9, 0, 0, 5};
    vecs[4] = '{11, 1, 1, 11, 0, 0, 6};
    vecs[5] = '{ 8, 1, 1,  8, 1, 1, 7};
`ifdef PERIOD_MON_STICKY_FAULT_EN
    vecs[6] = '{10, 1, 0,  8, 1, 1, 8};
    vecs[7] = '{11, 1, 0,  8, 1, 1, 9};
`else
    vecs[6] = '{10, 1, 1, 10, 0, 1, 8};
    vecs[7] = '{11, 1, 1, 11, 0, 1, 9};
`endif

    // Reset values.
    step(1'b1, 1'b0);
    chk("rst_period", int'(bus.period_out), 0);
    chk("rst_valid",  int'(bus.period_valid), 0);
    chk("rst_fault",  int'(bus.fault), 0);
    chk("rst_code",   int'(bus.fault_code), 0);
    chk("rst_pulse",  int'(bus.pulse_cnt), 0);

    // Vector table: nominal, wide pulses, tolerance edges, short fault.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("first_rise_valid", int'(bus.period_valid), 0);
    chk("first_rise_pulse", int'(bus.pulse_cnt), 1);
    prev_w = 1;
    for (int unsigned i = 0; i < 8; i++) begin
      run_to_rise(vecs[i].gap, prev_w);
      chk($sformatf("vec%0d_valid", i),  int'(bus.period_valid), vecs[i].valid);
      chk($sformatf("vec%0d_period", i), int'(bus.period_out),   vecs[i].period);
      chk($sformatf("vec%0d_fault", i),  int'(bus.fault),        vecs[i].fault);
      chk($sformatf("vec%0d_code", i),   int'(bus.fault_code),   vecs[i].code);
      chk($sformatf("vec%0d_pulse", i),  int'(bus.pulse_cnt),    vecs[i].pulse);
      prev_w = vecs[i].w;
    end
    step(1'b0, 1'b0);

    // Timeout: one rise, then silence; fault exactly LIM edges later.
    do_reset();
    step(1'b0, 1'b1);
    for (int j = 1; j < LIM; j++) begin
      step(1'b0, 1'b0);
      chk($sformatf("tmo_quiet%0d", j), int'(bus.fault), 0);
    end
    step(1'b0, 1'b0);
    chk("tmo_fault", int'(bus.fault), 1);
    chk("tmo_code",  int'(bus.fault_code), 3);
    step(1'b0, 1'b0);
`ifdef PERIOD_MON_STICKY_FAULT_EN
    chk("tmo_fault_hold", int'(bus.fault), 1);
`else
    chk("tmo_fault_pulse", int'(bus.fault), 0);
    step(1'b0, 1'b1);
    chk("tmo_rearmed_no_valid", int'(bus.period_valid), 0);
`endif

    // Period of exactly LIM reports timeout, not long.
    do_reset();
    step(1'b0, 1'b1);
    run_to_rise(LIM, 1);
    chk("lim_fault", int'(bus.fault), 1);
    chk("lim_code",  int'(bus.fault_code), 3);

    // Reset mid-measurement, asserted while sig_in rises.
    do_reset();
    step(1'b0, 1'b1);
    run_to_rise(10, 1);
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("midrst_period", int'(bus.period_out), 0);
    chk("midrst_valid",  int'(bus.period_valid), 0);
    chk("midrst_fault",  int'(bus.fault), 0);
    chk("midrst_code",   int'(bus.fault_code), 0);
    chk("midrst_pulse",  int'(bus.pulse_cnt), 0);
    step(1'b0, 1'b1);
    chk("rearm_pulse", int'(bus.pulse_cnt), 1);
    chk("rearm_valid", int'(bus.period_valid), 0);
    run_to_rise(10, 2);
    chk("rearm_period", int'(bus.period_out), 10);
    chk("rearm_pvalid", int'(bus.period_valid), 1);

    // Random pulse trains with occasional resets, model-checked each cycle.
    do_reset();
    ph = 0; gap = 2; w = 1;
    repeat (4000) begin
      if (ph == 0) begin
        gap = $urandom_range(14, 2);
        w   = $urandom_range(gap - 1, 1);
      end
      step(($urandom_range(149, 0) == 0), ph < w);
      ph = (ph + 1 == gap) ? 0 : ph + 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
